// File: rtl/door_pkg.sv
// Shared definitions for the door latch controller: state encodings, synchroniser depth, reset values.
package door_pkg;

  typedef logic [2:0] lock_state_t;

  localparam lock_state_t LOCKED   = 3'd0;
  localparam lock_state_t RELEASED = 3'd1;
  localparam lock_state_t OPEN     = 3'd2;
  localparam lock_state_t ALARM    = 3'd3;

  localparam int SYNC_DEPTH = 2;

  localparam lock_state_t RST_STATE = LOCKED;
  localparam logic        RST_LATCH = 1'b0;
  localparam logic        RST_WARN  = 1'b0;
  localparam logic        RST_ALARM = 1'b0;
  localparam logic        RST_SYNC  = 1'b0;

endpackage

// File: rtl/door_sync.sv
// N-flop synchroniser for a single asynchronous level input; q lags d by N clocks.
module door_sync
  import door_pkg::*;
#(
  parameter int N = SYNC_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr <= {N{RST_SYNC}};
    else       sr <= N'({sr, d});
  end

  assign q = sr[N-1];

endmodule

// File: rtl/door_lock_ctrl.sv
// Door latch actuator: unlock pulse -> timed solenoid release, ajar warning, forced-entry alarm.
// Forced-entry detection and the ALARM state are built only when DOOR_ALARM_EN is defined.
module door_lock_ctrl
  import door_pkg::*;
#(
  parameter int HOLD_CYCLES = 50,
  parameter int AJAR_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       unlock_req,
  input  logic       door_open,
  output logic       latch_release,
  output logic       ajar_warn,
  output logic       alarm,
  output logic [2:0] lock_state
);

  localparam int MAX_CYC = (HOLD_CYCLES > AJAR_CYCLES) ? HOLD_CYCLES : AJAR_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] AJAR_LOAD = TW'(AJAR_CYCLES - 1);

  logic          door_s;
  lock_state_t   state, nxt_state;
  logic [TW-1:0] tmr, nxt_tmr, tmr_dec;
  logic          nxt_warn;

  door_sync #(.N(SYNC_DEPTH)) u_door_sync (
    .clk   (clk),
    .reset (reset),
    .d     (door_open),
    .q     (door_s)
  );

  // Saturating decrement: the timer parks at zero instead of wrapping.
  assign tmr_dec = (tmr == '0) ? tmr : tmr - TW'(1);

  always_comb begin
    nxt_state = state;
    nxt_tmr   = tmr;
    nxt_warn  = 1'b0;
    case (state)
      RELEASED: begin
        nxt_tmr = tmr_dec;
        if (door_s) begin
          nxt_state = OPEN;
          nxt_tmr   = AJAR_LOAD;
        end else if (unlock_req) begin
          nxt_tmr   = HOLD_LOAD;
        end else if (tmr == '0) begin
          nxt_state = LOCKED;
        end
      end
      OPEN: begin
        nxt_tmr = tmr_dec;
        if (!door_s) nxt_state = LOCKED;
        else         nxt_warn  = ajar_warn | (tmr == '0);
      end
`ifdef DOOR_ALARM_EN
      ALARM: begin
        if (unlock_req && !door_s) nxt_state = LOCKED;
      end
`endif
      default: begin
        // LOCKED, plus any unused encoding
        if (unlock_req) begin
          nxt_state = RELEASED;
          nxt_tmr   = HOLD_LOAD;
        end else if (door_s) begin
`ifdef DOOR_ALARM_EN
          nxt_state = ALARM;
`else
          nxt_state = OPEN;
          nxt_tmr   = AJAR_LOAD;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RST_STATE;
      tmr           <= '0;
      latch_release <= RST_LATCH;
      ajar_warn     <= RST_WARN;
    end else begin
      state         <= nxt_state;
      tmr           <= nxt_tmr;
      latch_release <= (nxt_state == RELEASED);
      ajar_warn     <= nxt_warn;
    end
  end

`ifdef DOOR_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) alarm_q <= RST_ALARM;
    else       alarm_q <= (nxt_state == ALARM);
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  assign lock_state = state;

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed and random checks of door_lock_ctrl against a cycle-timestamp reference model.
`timescale 1ns/1ps
module tb_door_lock_ctrl;

  localparam int H = 8;
  localparam int A = 16;

`ifdef DOOR_ALARM_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       unlock_req = 1'b0;
  logic       door_open = 1'b0;
  logic       latch_release, ajar_warn, alarm;
  logic [2:0] lock_state;

  door_lock_ctrl #(.HOLD_CYCLES(H), .AJAR_CYCLES(A)) dut (
    .clk           (clk),
    .reset         (reset),
    .unlock_req    (unlock_req),
    .door_open     (door_open),
    .latch_release (latch_release),
    .ajar_warn     (ajar_warn),
    .alarm         (alarm),
    .lock_state    (lock_state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: mode 0 locked, 1 released, 2 open, 3 alarm; deadlines kept as absolute cycle numbers.
  int   m_mode = 0;
  int   rel_last = 0;
  int   open_start = 0;
  logic d_m1 = 1'b0;
  logic d_m2 = 1'b0;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0d want %0d", tag, cyc, got, want);
    end
  endtask

  task automatic check_model();
    chk("latch", {2'b00, latch_release}, {2'b00, m_mode == 1});
    chk("ajar",  {2'b00, ajar_warn},     {2'b00, (m_mode == 2) && (cyc >= open_start + A)});
    chk("alarm", {2'b00, alarm},         {2'b00, m_mode == 3});
    chk("state", lock_state,             3'(m_mode));
  endtask

  task automatic model_update(input logic u, input logic ds);
    case (m_mode)
      0: if (u) begin m_mode = 1; rel_last = cyc + H; end
         else if (ds) begin
           if (ALARM_ON) m_mode = 3;
           else begin m_mode = 2; open_start = cyc + 1; end
         end
      1: if (ds) begin m_mode = 2; open_start = cyc + 1; end
         else if (u) rel_last = cyc + H;
         else if (cyc == rel_last) m_mode = 0;
      2: if (!ds) m_mode = 0;
      default: if (u && !ds) m_mode = 0;
    endcase
  endtask

  // Drive cycle cyc's inputs, check outputs mid-cycle, advance the model and the clock.
  task automatic step(input logic u, input logic d);
    unlock_req = u;
    door_open  = d;
    @(negedge clk);
    check_model();
    model_update(u, d_m2);
    d_m2 = d_m1;
    d_m1 = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    unlock_req = 1'b0;
    door_open  = 1'b0;
    #1;
    chk("rst_latch", {2'b00, latch_release}, 3'd0);
    chk("rst_ajar",  {2'b00, ajar_warn},     3'd0);
    chk("rst_alarm", {2'b00, alarm},         3'd0);
    chk("rst_state", lock_state,             3'd0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    cyc    = 0;
    m_mode = 0;
    d_m1   = 1'b0;
    d_m2   = 1'b0;
  endtask

  initial begin
    logic d;

    // Plain unlock, door stays closed
    do_reset();
    for (int c = 0; c < 25; c++) begin
      if (c == 11 || c == 18) chk("s1_latch_hi", {2'b00, latch_release}, 3'd1);
      if (c == 19) begin
        chk("s1_latch_lo", {2'b00, latch_release}, 3'd0);
        chk("s1_locked", lock_state, 3'd0);
      end
      step(c == 10, 1'b0);
    end

    // Unlock, door opened, held open past the ajar limit, then closed
    do_reset();
    for (int c = 0; c < 50; c++) begin
      if (c == 15) chk("s2_released", lock_state, 3'd1);
      if (c == 16) begin
        chk("s2_open", lock_state, 3'd2);
        chk("s2_latch_lo", {2'b00, latch_release}, 3'd0);
      end
      if (c == 31) chk("s2_ajar_pre", {2'b00, ajar_warn}, 3'd0);
      if (c == 40) chk("s2_ajar_on", {2'b00, ajar_warn}, 3'd1);
      if (c == 43) begin
        chk("s2_ajar_clr", {2'b00, ajar_warn}, 3'd0);
        chk("s2_relock", lock_state, 3'd0);
      end
      step(c == 10, (c >= 13) && (c < 40));
    end

    // Forced entry from LOCKED
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (ALARM_ON) begin
        if (c == 8) chk("s3_alarm_on", {2'b00, alarm}, 3'd1);
        if (c == 13) chk("s3_alarm_hold", lock_state, 3'd3);
        if (c == 31) chk("s3_alarm_clr", {2'b00, alarm}, 3'd0);
        d = (c >= 5) && (c < 20);
      end else begin
        if (c == 8) chk("s3_open", lock_state, 3'd2);
        if (c == 24) chk("s3_ajar", {2'b00, ajar_warn}, 3'd1);
        if (c == 33) chk("s3_relock", lock_state, 3'd0);
        d = (c >= 5) && (c < 30);
      end
      step(c == 12 || c == 30, d);
    end

    // Second unlock pulse while released extends the hold
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 24) chk("s4_latch_ext", {2'b00, latch_release}, 3'd1);
      if (c == 25) chk("s4_latch_end", {2'b00, latch_release}, 3'd0);
      step(c == 10 || c == 16, 1'b0);
    end

    // Reset mid-hold
    do_reset();
    for (int c = 0; c < 14; c++) step(c == 10, 1'b0);
    chk("s5_pre_rst", {2'b00, latch_release}, 3'd1);
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0);

    // Random traffic against the model
    do_reset();
    d = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 24) == 0) d = ~d;
      step($urandom_range(0, 7) == 0, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/door_lock_ctrl.md
# door_lock_ctrl

Downstream actuator stage for the serial code-detect FSM: consumes its one-cycle unlock pulse and drives the door latch solenoid. Holds the latch released for a bounded window and tracks the door-open sensor through a synchroniser. Raises an ajar warning when the door stays open too long and a sticky alarm on forced entry. All outputs are registered.

## Interface
- HOLD_CYCLES, default 50, cycles the latch stays released waiting for the door to open; must be ≥1.
- AJAR_CYCLES, default 200, cycles the door may stay open before ajar_warn; must be ≥1.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high; clock clk.
- unlock_req  input  1  one-cycle pulse from the code-detect FSM (correct code entered).
- door_open  input  1  raw door sensor (1 = open), asynchronous to clk.
- latch_release  output  1  1 = solenoid energised (door unlatched).
- ajar_warn  output  1  door open longer than AJAR_CYCLES.
- alarm  output  1  forced-entry alarm, sticky.
- lock_state  output  3  current state encoding, for status/debug.

## Operation
- door_open passes through a 2-flop synchroniser to door_s; all logic uses door_s only.
- One down-counter `tmr`, width $clog2(max(HOLD_CYCLES,AJAR_CYCLES)+1), shared by RELEASED and OPEN; it saturates at 0 and never wraps.
- LOCKED (3'd0): latch_release=0. If unlock_req, load tmr=HOLD_CYCLES-1 and go to RELEASED. Else if door_s, go to ALARM.
- RELEASED (3'd1): latch_release=1, tmr decrements.
  - If door_s, load tmr=AJAR_CYCLES-1 and go to OPEN. door_s takes priority over timer expiry and over unlock_req.
  - Else if unlock_req, reload tmr=HOLD_CYCLES-1 and stay.
  - Else if tmr==0, go to LOCKED.
- OPEN (3'd2): latch_release=0, so the bolt re-arms for closing.
  - tmr decrements; ajar_warn=1 once tmr has reached 0, and it stays 1 while in OPEN.
  - !door_s: go to LOCKED and clear ajar_warn. unlock_req is ignored.
- ALARM (3'd3): alarm=1, latch_release=0.
  - unlock_req with !door_s: go to LOCKED and clear alarm.
  - unlock_req while door_s: ignored.
- Unused encodings decode to LOCKED.
- Reset, at any time including mid-hold or mid-alarm, forces LOCKED: latch_release=0, ajar_warn=0, alarm=0, lock_state=0, tmr=0, synchroniser flops=0.

## Timing
- unlock_req high in cycle N: latch_release=1 from N+1.
- With the door kept closed, latch_release stays high for exactly HOLD_CYCLES cycles.
- door_open edge to door_s: 2 cycles. door_s to the state change: 1 further cycle.
- OPEN entered in cycle M: ajar_warn=1 from cycle M+AJAR_CYCLES.
- Door closes during OPEN: ajar_warn and the OPEN state clear 3 cycles after the raw door_open edge.
- unlock_req held high for several cycles in RELEASED: the timer is continually reloaded. This is not an error.

## Configuration
- DOOR_ALARM_EN defined: forced-entry detection and the ALARM state exist as described above.
- DOOR_ALARM_EN undefined:
  - alarm is tied to 0 and the ALARM state logic is not built.
  - door_s in LOCKED goes to OPEN with tmr=AJAR_CYCLES-1, so a forced door still produces ajar_warn.

## Structure
- Package door_pkg holds:
  - the state typedef (LOCKED, RELEASED, OPEN, ALARM) with the fixed 3-bit encodings above;
  - the synchroniser depth constant (2);
  - the reset-value constants.
- One sub-module, door_sync: a parameterised N-flop synchroniser with asynchronous active-high reset, instantiated once for door_open.
- The FSM, timer and output registers live in door_lock_ctrl.

## Test plan
Bench parameters: HOLD_CYCLES=8, AJAR_CYCLES=16.
- Pulse unlock_req at cycle 10 with the door closed → latch_release=1 in cycles 11–18, 0 at 19; lock_state returns to 0.
- Pulse unlock_req at 10, raise door_open at 13 → OPEN at 16 with latch_release=0; ajar_warn=1 at 32; drop door_open at 40 → ajar_warn=0 and LOCKED at 43.
- With DOOR_ALARM_EN, raise door_open in LOCKED at 5 → alarm=1 at 8. unlock_req at 12 while the door is open → no change. Drop the door at 20, unlock_req at 30 → alarm=0 at 31.
- Without DOOR_ALARM_EN, the same forced open → alarm stays 0, OPEN entered, ajar_warn after 16 cycles.
- In RELEASED, pulse unlock_req again at cycle 16 (first pulse at 10) → latch_release high through cycle 24.
- Assert reset at cycle 14 while latch_release=1 → all outputs 0 immediately (asynchronous), LOCKED after reset is released.
